// File: rtl/bus_pkg.sv
// Shared constants for the multi-master bus: FSM encoding, arbitration modes, default timeout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bus_pkg;

  // FSM encoding, kept as plain constants so legacy tools can read it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Arbitration modes
  localparam int ARB_FIXED = 0;  // master 0 highest priority
  localparam int ARB_RR    = 1;  // round-robin after the last completed grantee

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_arbiter.sv
// Picks one requesting master: fixed priority (index 0 first) or round-robin after ptr_i.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when the winner is taken.
//   req_i  : request vector, one bit per master
//   ptr_i  : index of the last completed grantee (round-robin only)
//   gnt_o  : one-hot winner, zero when no request
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_MODE    = ARB_RR,
  localparam int PTR_W      = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [PTR_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk NUM_MASTERS candidates in priority order; the first requester wins.
  // Round-robin starts one above ptr_i and wraps to 0.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        idx = PTR_W'(k - 1);
      end else begin
        idx = PTR_W'((int'(ptr_i) + k) % NUM_MASTERS);
      end
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_master_bus.sv
// Shares one slave port between NUM_MASTERS masters with fixed or round-robin arbitration and a BUSY timeout.
// Latency: request -> slave strobe 1 cycle; m_ready in the same cycle as s_ready.
// Backpressure: masters hold request until m_ready; s_ready stalls BUSY up to TIMEOUT_CYC cycles, then ERR.
//   clk, rst                         : clock, async active-low reset
//   m_addr/m_wdata/m_read/m_write    : packed master requests (slice i = master i)
//   m_rdata/m_ready/m_err            : per-master response, zero for non-granted masters
//   s_addr/s_wdata/s_read/s_write    : slave request, mirrors the granted master in BUSY
//   s_rdata/s_ready                  : slave response
//   grant                            : registered one-hot grant, zero when idle
module multi_master_bus
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 8,
  parameter int ARB_MODE    = ARB_RR,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_read,
  output logic                          s_write,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [NUM_MASTERS-1:0]        grant
);

  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_MASTERS - 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       gidx_q, gidx_d;   // binary copy of grant_q for muxing
  logic [PTR_W-1:0]       ptr_q, ptr_d;     // last completed grantee
  logic [CNT_W-1:0]       cnt_q, cnt_d;     // BUSY cycles without s_ready

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] win;
  logic [PTR_W-1:0]       win_idx;

  assign req   = m_read | m_write;
  assign grant = grant_q;

  bus_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    m_rdata = '0;
    m_ready = '0;
    m_err   = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_read  = 1'b0;
    s_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = win;
          gidx_d  = win_idx;
          cnt_d   = '0;
          // Read and write together is illegal: never show it to the slave.
          state_d = (m_read[win_idx] && m_write[win_idx]) ? ST_ERR : ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_addr  = m_addr[int'(gidx_q)*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[int'(gidx_q)*DATA_W +: DATA_W];
        s_read  = m_read[gidx_q];
        s_write = m_write[gidx_q];
        if (!req[gidx_q]) begin
          // Master withdrew: silent abort, fairness pointer untouched.
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (s_ready) begin
          m_ready[gidx_q] = 1'b1;
          if (m_read[gidx_q]) m_rdata[int'(gidx_q)*DATA_W +: DATA_W] = s_rdata;
          ptr_d   = gidx_q;
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        m_ready[gidx_q] = 1'b1;
        m_err[gidx_q]   = 1'b1;
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
